// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types and default widths for the hazard controller.
package pipeline_hazard_ctrl_pkg;
    typedef enum logic [1:0] {RUN, DWAIT, IWAIT} hz_state_e;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam int XLEN_D = 32;
    localparam int REG_AW_D = 5;
    localparam int CNT_W_D = 32;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-to-hazard-controller bundle; master is the pipeline, slave the controller.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int REG_AW = REG_AW_D
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = CNT_W_D
`endif
);
    logic [REG_AW-1:0] rs1_addr_ID;
    logic [REG_AW-1:0] rs2_addr_ID;
    logic rs1_used_ID;
    logic rs2_used_ID;
    logic [REG_AW-1:0] rd_addr_EX;
    logic MemRead_EX;
    logic branch_taken_EX;
    logic [XLEN-1:0] branch_target_EX;
    logic imem_ready;
    logic dmem_req_MEM;
    logic dmem_ready;
    logic PCWrite;
    logic pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic en_IFID;
    logic NOP_IFID;
    logic en_IDEX;
    logic NOP_IDEX;
    logic en_EXMEM;
    logic en_MEMWB;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] dwait_cnt;
`endif
    modport master (
        output rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID, rd_addr_EX, MemRead_EX,
               branch_taken_EX, branch_target_EX, imem_ready, dmem_req_MEM, dmem_ready,
        input  PCWrite, pc_redirect, pc_target, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, en_MEMWB
`ifdef HAZ_PERF_CNT_EN
        , input stall_cnt, flush_cnt, dwait_cnt
`endif
    );
    modport slave (
        input  rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID, rd_addr_EX, MemRead_EX,
               branch_taken_EX, branch_target_EX, imem_ready, dmem_req_MEM, dmem_ready,
        output PCWrite, pc_redirect, pc_target, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, en_MEMWB
`ifdef HAZ_PERF_CNT_EN
        , output stall_cnt, flush_cnt, dwait_cnt
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// pipeline_hazard_ctrl_hazard_detect: load-use compare between the ID sources and a load in EX.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_D
) (
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic              i_mem_read,
    output logic              o_load_use_hit
);
    assign o_load_use_hit = i_mem_read && (i_rd_addr != '0) &&
                            ((i_rs1_used && (i_rs1_addr == i_rd_addr)) ||
                             (i_rs2_used && (i_rs2_addr == i_rd_addr)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, EX redirect, imem/dmem wait).
// Defining HAZ_PERF_CNT_EN adds saturating stall/flush/dwait performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_D,
    parameter int REG_AW = REG_AW_D
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = CNT_W_D
`endif
) (
    input logic clk_HAZ,
    input logic rst_HAZ,
    pipeline_hazard_ctrl_if.slave hz
);
    hz_state_e r_state;
    hz_state_e w_nstate;
    logic r_pend;
    logic w_npend;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] w_ntarget;
    logic w_load_use;
    logic w_dstall;
    logic w_pend_live;
    logic w_stall;
    logic w_flush;
    logic w_dfreeze;

    pipeline_hazard_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .i_rs1_addr    (hz.rs1_addr_ID),
        .i_rs2_addr    (hz.rs2_addr_ID),
        .i_rs1_used    (hz.rs1_used_ID),
        .i_rs2_used    (hz.rs2_used_ID),
        .i_rd_addr     (hz.rd_addr_EX),
        .i_mem_read    (hz.MemRead_EX),
        .o_load_use_hit(w_load_use)
    );

    assign w_dstall = hz.dmem_req_MEM && !hz.dmem_ready;
    // A pending redirect only exists while waiting on imem or frozen by dmem.
    assign w_pend_live = r_pend && (r_state != RUN);

    always_comb begin
        hz.PCWrite = 1'b1;
        hz.pc_redirect = 1'b0;
        hz.pc_target = (w_pend_live && !hz.branch_taken_EX) ? r_pend_target : hz.branch_target_EX;
        hz.en_IFID = 1'b1;
        hz.NOP_IFID = 1'b0;
        hz.en_IDEX = 1'b1;
        hz.NOP_IDEX = 1'b0;
        hz.en_EXMEM = 1'b1;
        hz.en_MEMWB = 1'b1;
        w_nstate = RUN;
        w_npend = r_pend;
        w_ntarget = r_pend_target;
        w_stall = 1'b0;
        w_flush = 1'b0;
        w_dfreeze = 1'b0;
        if (rst_HAZ) begin
            hz.PCWrite = 1'b0;
        end else if (w_dstall) begin
            hz.PCWrite = 1'b0;
            hz.en_IFID = 1'b0;
            hz.en_IDEX = 1'b0;
            hz.en_EXMEM = 1'b0;
            hz.en_MEMWB = 1'b0;
            w_nstate = DWAIT;
            w_dfreeze = 1'b1;
        end else if (hz.branch_taken_EX) begin
            hz.NOP_IFID = 1'b1;
            hz.NOP_IDEX = 1'b1;
            w_flush = 1'b1;
            if (hz.imem_ready) begin
                hz.pc_redirect = 1'b1;
                w_npend = 1'b0;
            end else begin
                hz.PCWrite = 1'b0;
                w_npend = 1'b1;
                w_ntarget = hz.branch_target_EX;
                w_nstate = IWAIT;
            end
        end else if (w_pend_live) begin
            // The word arriving now belongs to the wrong path, so it is bubbled.
            hz.NOP_IFID = 1'b1;
            if (hz.imem_ready) begin
                hz.pc_redirect = 1'b1;
                w_npend = 1'b0;
            end else begin
                hz.PCWrite = 1'b0;
                w_nstate = IWAIT;
            end
        end else if (w_load_use) begin
            hz.PCWrite = 1'b0;
            hz.en_IFID = 1'b0;
            hz.NOP_IDEX = 1'b1;
            w_stall = 1'b1;
        end else if (!hz.imem_ready) begin
            hz.PCWrite = 1'b0;
            hz.NOP_IFID = 1'b1;
            w_nstate = IWAIT;
        end
    end

    always_ff @(posedge clk_HAZ) begin
        if (rst_HAZ) begin
            r_state <= RUN;
            r_pend <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_state <= w_nstate;
            r_pend <= w_npend;
            r_pend_target <= w_ntarget;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_dwait_cnt;

    always_ff @(posedge clk_HAZ) begin
        if (rst_HAZ) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_dwait_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall && !(&r_stall_cnt));
            r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush && !(&r_flush_cnt));
            r_dwait_cnt <= r_dwait_cnt + CNT_W'(w_dfreeze && !(&r_dwait_cnt));
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
    assign hz.dwait_cnt = r_dwait_cnt;
`endif
endmodule
